// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for one UART RX channel: start detection, bit/edge counting,
// check-block enables and the per-frame data_valid / frame_err verdict.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6,
    localparam int BW        = $clog2(DATA_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               par_en,
    input  logic               start_glitch,
    input  logic               parity_error,
    input  logic               stop_error,
    output logic               data_samp_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BW-1:0]      bit_cnt,
    output logic               start_check_en,
    output logic               deser_en,
    output logic               parity_check_en,
    output logic               stop_check_en,
    output logic               data_valid,
    output logic               frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]         state_q, state_nx;
    logic [PRESC_W-1:0] p_q, s_val, e_val, edge_nx;
    logic [BW-1:0]      bit_nx;
    logic               par_en_q, par_err_q;
    logic               at_end, detect, en_tick;

    always_comb begin
        s_val    = (p_q >> 1) + PRESC_W'(2);
        e_val    = p_q - PRESC_W'(1);
        at_end   = (edge_cnt == e_val);
        detect   = (state_q == IDLE) && !rx_in;
        state_nx = state_q;
        bit_nx   = bit_cnt;
        edge_nx  = '0;
        if (state_q != IDLE)
            edge_nx = at_end ? '0 : edge_cnt + PRESC_W'(1);
        case (state_q)
            IDLE: begin
                bit_nx = '0;
                if (!rx_in) state_nx = START;
            end
            START: if (at_end) begin
                state_nx = start_glitch ? IDLE : DATA;
                bit_nx   = '0;
            end
            DATA: if (at_end) begin
                if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                    state_nx = par_en_q ? PARITY : STOP;
                    bit_nx   = '0;
                end else begin
                    bit_nx = bit_cnt + BW'(1);
                end
            end
            PARITY: if (at_end) state_nx = STOP;
            STOP:   if (at_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Enables are registered, so they look ahead at the next tick to line up with edge_cnt.
        en_tick = (state_nx != IDLE) && (edge_nx == s_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            edge_cnt        <= '0;
            bit_cnt         <= '0;
            p_q             <= '0;
            par_en_q        <= 1'b0;
            par_err_q       <= 1'b0;
            data_samp_en    <= 1'b0;
            start_check_en  <= 1'b0;
            deser_en        <= 1'b0;
            parity_check_en <= 1'b0;
            stop_check_en   <= 1'b0;
            data_valid      <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            state_q         <= state_nx;
            edge_cnt        <= edge_nx;
            bit_cnt         <= bit_nx;
            data_samp_en    <= (state_nx != IDLE);
            start_check_en  <= en_tick && (state_nx == START);
            deser_en        <= en_tick && (state_nx == DATA);
            parity_check_en <= en_tick && (state_nx == PARITY);
            stop_check_en   <= en_tick && (state_nx == STOP);
            if (detect) begin
                p_q       <= (prescale < PRESC_W'(8)) ? PRESC_W'(8) : prescale;
                par_en_q  <= par_en;
                par_err_q <= 1'b0;
            end else if (state_q == PARITY && at_end) begin
                par_err_q <= parity_error;
            end
            // Verdict appears the cycle after the last STOP tick, once stop_error is settled.
            data_valid <= (state_q == STOP) && at_end && !stop_error && !par_err_q;
            frame_err  <= (state_q == STOP) && at_end && (stop_error || par_err_q);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; the check blocks are stood in for by registered responders.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       start_glitch = 1'b0;
    logic       parity_error = 1'b0;
    logic       stop_error = 1'b0;
    logic       data_samp_en, start_check_en, deser_en, parity_check_en, stop_check_en;
    logic       data_valid, frame_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;

    logic cfg_glitch = 1'b0, cfg_par = 1'b0, cfg_stop = 1'b0, stale_req = 1'b0;

    int errors = 0, checks = 0;
    int t, exp_s;
    int n_samp, n_sc, n_de, n_pc, n_stc, n_dv, n_fe, bad_edge, bad_bit, t_dv, t_fe, t_pc;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
        .start_glitch(start_glitch), .parity_error(parity_error), .stop_error(stop_error),
        .data_samp_en(data_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .start_check_en(start_check_en), .deser_en(deser_en),
        .parity_check_en(parity_check_en), .stop_check_en(stop_check_en),
        .data_valid(data_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Check-block stand-ins: result registered one cycle after the enable, then held.
    always @(posedge clk) begin
        if (stale_req) begin
            start_glitch <= 1'b1;
            parity_error <= 1'b1;
            stop_error   <= 1'b1;
        end else begin
            if (start_check_en)  start_glitch <= cfg_glitch;
            if (parity_check_en) parity_error <= cfg_par;
            if (stop_check_en)   stop_error   <= cfg_stop;
        end
    end

    task automatic clr_obs();
        t = 0; n_samp = 0; n_sc = 0; n_de = 0; n_pc = 0; n_stc = 0; n_dv = 0; n_fe = 0;
        bad_edge = 0; bad_bit = 0; t_dv = -1; t_fe = -1; t_pc = -1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        if (data_samp_en) n_samp++;
        if (start_check_en) begin n_sc++; if (int'(edge_cnt) != exp_s) bad_edge++; end
        if (deser_en) begin
            if (int'(edge_cnt) != exp_s) bad_edge++;
            if (int'(bit_cnt) != n_de) bad_bit++;
            n_de++;
        end
        if (parity_check_en) begin n_pc++; t_pc = t; if (int'(edge_cnt) != exp_s) bad_edge++; end
        if (stop_check_en) begin n_stc++; if (int'(edge_cnt) != exp_s) bad_edge++; end
        if (data_valid) begin n_dv++; t_dv = t; end
        if (frame_err) begin n_fe++; t_fe = t; end
        t++;
    endtask

    task automatic start_frame(input logic [5:0] pres, input logic pe, input int s);
        clr_obs();
        exp_s = s; prescale = pres; par_en = pe; rx_in = 1'b0;
        tick();
        rx_in = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_in = 1'b0;
        run(2);
        checks++;
        if ({data_samp_en, start_check_en, deser_en, parity_check_en, stop_check_en,
             data_valid, frame_err} !== 7'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0000000",
                {data_samp_en, start_check_en, deser_en, parity_check_en, stop_check_en,
                 data_valid, frame_err});
        end
        checks++;
        if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnts: got edge=%0d bit=%0d expected 0 0", edge_cnt, bit_cnt);
        end
        rx_in = 1'b1; rst = 1'b0;
        run(2);
    endtask

    task automatic test_frame_p8();
        start_frame(6'd8, 1'b0, 6);
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (k == 35) begin
                checks++;
                if (bit_cnt !== 4'd3 || edge_cnt !== 6'd3) begin
                    errors++; $display("FAIL p8_mid: got bit=%0d edge=%0d expected 3 3", bit_cnt, edge_cnt);
                end
            end
        end
        checks++;
        if (n_de != 8 || bad_bit != 0) begin
            errors++; $display("FAIL p8_deser: got %0d pulses bad_bit=%0d expected 8 0", n_de, bad_bit);
        end
        checks++;
        if (bad_edge != 0) begin errors++; $display("FAIL p8_edge: got %0d off-tick enables expected 0", bad_edge); end
        checks++;
        if (n_sc != 1 || n_stc != 1 || n_pc != 0) begin
            errors++; $display("FAIL p8_en: got sc=%0d stc=%0d pc=%0d expected 1 1 0", n_sc, n_stc, n_pc);
        end
        checks++;
        if (n_dv != 1 || t_dv != 80 || n_fe != 0) begin
            errors++; $display("FAIL p8_valid: got dv=%0d at %0d fe=%0d expected 1 at 80 fe 0", n_dv, t_dv, n_fe);
        end
        checks++;
        if (n_samp != 80 || data_samp_en !== 1'b0) begin
            errors++; $display("FAIL p8_samp: got %0d cycles expected 80 then idle", n_samp);
        end
    endtask

    task automatic test_parity_ok_p16();
        stale_req = 1'b1; tick(); stale_req = 1'b0;
        start_frame(6'd16, 1'b1, 10);
        run(176);
        checks++;
        if (n_pc != 1 || t_pc != 154) begin
            errors++; $display("FAIL p16_parity_en: got %0d at %0d expected 1 at 154", n_pc, t_pc);
        end
        checks++;
        if (bad_edge != 0 || n_de != 8) begin
            errors++; $display("FAIL p16_edge: got bad=%0d de=%0d expected 0 8", bad_edge, n_de);
        end
        checks++;
        if (n_dv != 1 || t_dv != 176 || n_fe != 0) begin
            errors++; $display("FAIL p16_valid: got dv=%0d at %0d fe=%0d expected 1 at 176 fe 0", n_dv, t_dv, n_fe);
        end
    endtask

    task automatic test_glitch();
        cfg_glitch = 1'b1;
        start_frame(6'd8, 1'b0, 6);
        run(8);
        checks++;
        if (data_samp_en !== 1'b0 || n_sc != 1) begin
            errors++; $display("FAIL glitch_idle: got samp=%b sc=%0d expected 0 1", data_samp_en, n_sc);
        end
        run(20);
        checks++;
        if (n_de != 0 || n_dv != 0 || n_fe != 0 || n_samp != 8) begin
            errors++; $display("FAIL glitch_quiet: got de=%0d dv=%0d fe=%0d samp=%0d expected 0 0 0 8",
                n_de, n_dv, n_fe, n_samp);
        end
        cfg_glitch = 1'b0;
        start_frame(6'd8, 1'b0, 6);
        run(80);
        checks++;
        if (n_de != 8 || n_dv != 1 || t_dv != 80) begin
            errors++; $display("FAIL glitch_restart: got de=%0d dv=%0d at %0d expected 8 1 at 80", n_de, n_dv, t_dv);
        end
    endtask

    task automatic test_errors();
        cfg_par = 1'b1;
        start_frame(6'd8, 1'b1, 6);
        run(90);
        checks++;
        if (n_fe != 1 || t_fe != 88 || n_dv != 0) begin
            errors++; $display("FAIL parity_err: got fe=%0d at %0d dv=%0d expected 1 at 88 dv 0", n_fe, t_fe, n_dv);
        end
        cfg_par = 1'b0; cfg_stop = 1'b1;
        start_frame(6'd8, 1'b1, 6);
        run(90);
        checks++;
        if (n_fe != 1 || t_fe != 88 || n_dv != 0) begin
            errors++; $display("FAIL stop_err: got fe=%0d at %0d dv=%0d expected 1 at 88 dv 0", n_fe, t_fe, n_dv);
        end
        cfg_stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_frame(6'd8, 1'b0, 6);
        run(35);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({data_samp_en, start_check_en, deser_en, parity_check_en, stop_check_en,
             data_valid, frame_err} !== 7'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
            errors++; $display("FAIL rst_mid: got samp=%b edge=%0d bit=%0d expected all 0",
                data_samp_en, edge_cnt, bit_cnt);
        end
        clr_obs();
        run(100);
        checks++;
        if (n_samp + n_sc + n_de + n_pc + n_stc + n_dv + n_fe != 0) begin
            errors++; $display("FAIL rst_quiet: got %0d active cycles expected 0",
                n_samp + n_sc + n_de + n_pc + n_stc + n_dv + n_fe);
        end
    endtask

    task automatic test_prescale();
        start_frame(6'd4, 1'b0, 6);
        run(80);
        checks++;
        if (n_dv != 1 || t_dv != 80 || bad_edge != 0) begin
            errors++; $display("FAIL presc_clamp: got dv=%0d at %0d bad=%0d expected 1 at 80 0", n_dv, t_dv, bad_edge);
        end
        start_frame(6'd8, 1'b0, 6);
        prescale = 6'd32; par_en = 1'b1;
        run(80);
        checks++;
        if (n_dv != 1 || t_dv != 80 || n_pc != 0 || bad_edge != 0) begin
            errors++; $display("FAIL presc_hold: got dv=%0d at %0d pc=%0d bad=%0d expected 1 at 80 0 0",
                n_dv, t_dv, n_pc, bad_edge);
        end
        par_en = 1'b0;
        start_frame(6'd32, 1'b0, 18);
        run(320);
        checks++;
        if (n_dv != 1 || t_dv != 320 || n_de != 8 || bad_edge != 0) begin
            errors++; $display("FAIL presc_32: got dv=%0d at %0d de=%0d bad=%0d expected 1 at 320 8 0",
                n_dv, t_dv, n_de, bad_edge);
        end
    endtask

    initial begin
        clr_obs();
        exp_s = 6;
        test_reset();
        test_frame_p8();
        test_parity_ok_p16();
        test_glitch();
        test_errors();
        test_reset_mid();
        test_prescale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
